// File: rtl/sobel_line_sched.sv
// ============================================================================
// Module   : sobel_line_sched
// Purpose  : Raster/line-buffer scheduler for the 3x3 Sobel window datapath.
// Optional : SCHED_OVERRUN_FLAG_EN adds a sticky overrun output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sobel_line_sched #(
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int CNT_W        = 12
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             input_data_valid,
    output logic [CNT_W-1:0] in_col,
    output logic [CNT_W-1:0] in_line,
    output logic             lb_wr_en,
    output logic [1:0]       lb_wr_sel,
    output logic             window_valid,
    output logic [CNT_W-1:0] out_col,
    output logic [CNT_W-1:0] out_line,
    output logic             border,
    output logic             flush_active,
    output logic             frame_done
`ifdef SCHED_OVERRUN_FLAG_EN
    ,
    output logic             overrun
`endif
);

    localparam logic [CNT_W-1:0] c_col_last  = CNT_W'(IMAGE_WIDTH - 1);
    localparam logic [CNT_W-1:0] c_line_last = CNT_W'(IMAGE_HEIGHT - 1);
    localparam logic [CNT_W-1:0] c_width     = CNT_W'(IMAGE_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] in_col_q, in_col_d, in_line_q, in_line_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [CNT_W-1:0] s_col_q, s_col_d, s_line_q, s_line_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] out_col_q, out_col_d, out_line_q, out_line_d;
    logic             border_q, border_d;
    logic             accept, step;
`ifdef SCHED_OVERRUN_FLAG_EN
    logic             overrun_q, overrun_d;
`endif

    always_comb begin
        state_d    = state_q;
        in_col_d   = in_col_q;
        in_line_d  = in_line_q;
        sel_d      = sel_q;
        k_d        = k_q;
        s_col_d    = s_col_q;
        s_line_d   = s_line_q;
        out_col_d  = out_col_q;
        out_line_d = out_line_q;
        border_d   = border_q;
        step       = 1'b0;
        accept     = input_data_valid &&
                     (state_q == S_IDLE || state_q == S_FILL || state_q == S_RUN);

        if (accept) begin
            if (in_col_q == c_col_last) begin
                in_col_d  = '0;
                in_line_d = (in_line_q == c_line_last) ? '0 : in_line_q + 1'b1;
                sel_d     = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
            end else begin
                in_col_d = in_col_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_FILL;
                    k_d     = CNT_W'(1);
                end
            end
            S_FILL: begin
                // k counts accepted pixels; the one making it WIDTH+1 starts RUN
                if (accept) begin
                    k_d = k_q + 1'b1;
                    if (k_q == c_width) state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    step = 1'b1;
                    if (in_col_q == c_col_last && in_line_q == c_line_last) begin
                        state_d = S_FLUSH;
                        k_d     = '0;
                    end
                end
            end
            S_FLUSH: begin
                step = 1'b1;
                k_d  = k_q + 1'b1;
                if (k_q == c_width) state_d = S_DONE;
            end
            S_DONE: begin
                state_d   = S_IDLE;
                in_col_d  = '0;
                in_line_d = '0;
                sel_d     = 2'd0;
                k_d       = '0;
                s_col_d   = '0;
                s_line_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase

        // The step counter names the next window centre in raster order
        if (step) begin
            out_col_d  = s_col_q;
            out_line_d = s_line_q;
            border_d   = (s_col_q == '0) || (s_col_q == c_col_last) ||
                         (s_line_q == '0) || (s_line_q == c_line_last);
            if (s_col_q == c_col_last) begin
                s_col_d  = '0;
                s_line_d = (s_line_q == c_line_last) ? '0 : s_line_q + 1'b1;
            end else begin
                s_col_d = s_col_q + 1'b1;
            end
        end
        valid_d = step;
    end

`ifdef SCHED_OVERRUN_FLAG_EN
    always_comb begin
        overrun_d = overrun_q |
                    (input_data_valid && (state_q == S_FLUSH || state_q == S_DONE));
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            in_col_q   <= '0;
            in_line_q  <= '0;
            sel_q      <= 2'd0;
            k_q        <= '0;
            s_col_q    <= '0;
            s_line_q   <= '0;
            valid_q    <= 1'b0;
            out_col_q  <= '0;
            out_line_q <= '0;
            border_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_col_q   <= in_col_d;
            in_line_q  <= in_line_d;
            sel_q      <= sel_d;
            k_q        <= k_d;
            s_col_q    <= s_col_d;
            s_line_q   <= s_line_d;
            valid_q    <= valid_d;
            out_col_q  <= out_col_d;
            out_line_q <= out_line_d;
            border_q   <= border_d;
        end
    end

`ifdef SCHED_OVERRUN_FLAG_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) overrun_q <= 1'b0;
        else         overrun_q <= overrun_d;
    end
    assign overrun = overrun_q;
`endif

    assign in_col       = in_col_q;
    assign in_line      = in_line_q;
    assign lb_wr_en     = accept;
    assign lb_wr_sel    = sel_q;
    assign window_valid = valid_q;
    assign out_col      = out_col_q;
    assign out_line     = out_line_q;
    assign border       = border_q;
    assign flush_active = (state_q == S_FLUSH);
    assign frame_done   = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_sobel_line_sched.sv
// ============================================================================
// Module   : tb_sobel_line_sched
// Purpose  : Directed, table-driven bench for sobel_line_sched (4x3 image).
// Optional : SCHED_OVERRUN_FLAG_EN enables the overrun checks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sobel_line_sched;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          resetn;
    logic          input_data_valid;
    logic [CW-1:0] in_col, in_line, out_col, out_line;
    logic          lb_wr_en, window_valid, border, flush_active, frame_done;
    logic [1:0]    lb_wr_sel;
`ifdef SCHED_OVERRUN_FLAG_EN
    logic          overrun;
`endif

    sobel_line_sched #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .CNT_W(CW)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .input_data_valid (input_data_valid),
        .in_col           (in_col),
        .in_line          (in_line),
        .lb_wr_en         (lb_wr_en),
        .lb_wr_sel        (lb_wr_sel),
        .window_valid     (window_valid),
        .out_col          (out_col),
        .out_line         (out_line),
        .border           (border),
        .flush_active     (flush_active),
        .frame_done       (frame_done)
`ifdef SCHED_OVERRUN_FLAG_EN
        ,
        .overrun          (overrun)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v;
        logic we;
        int   sel;
        int   col;
        int   line;
        logic wv;
        int   oc;
        int   ol;
        logic bd;
        logic fl;
        logic dn;
    } vec_t;

    vec_t tbl[19];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic v, logic we, int sel, int col, int line,
                                logic wv, int oc, int ol, logic bd, logic fl, logic dn);
        vec_t r;
        r.v = v; r.we = we; r.sel = sel; r.col = col; r.line = line;
        r.wv = wv; r.oc = oc; r.ol = ol; r.bd = bd; r.fl = fl; r.dn = dn;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Applies rows [first, first+n) of the table, one clock cycle per row.
    task automatic apply_rows(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            input_data_valid = tbl[i].v;
            @(negedge clk);
            chk($sformatf("r%0d_wr_en", i),   int'(lb_wr_en),     int'(tbl[i].we));
            chk($sformatf("r%0d_wr_sel", i),  int'(lb_wr_sel),    tbl[i].sel);
            chk($sformatf("r%0d_in_col", i),  int'(in_col),       tbl[i].col);
            chk($sformatf("r%0d_in_line", i), int'(in_line),      tbl[i].line);
            chk($sformatf("r%0d_wvalid", i),  int'(window_valid), int'(tbl[i].wv));
            chk($sformatf("r%0d_flush", i),   int'(flush_active), int'(tbl[i].fl));
            chk($sformatf("r%0d_done", i),    int'(frame_done),   int'(tbl[i].dn));
            if (tbl[i].wv) begin
                chk($sformatf("r%0d_out_col", i),  int'(out_col),  tbl[i].oc);
                chk($sformatf("r%0d_out_line", i), int'(out_line), tbl[i].ol);
                chk($sformatf("r%0d_border", i),   int'(border),   int'(tbl[i].bd));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_col"},   int'(in_col),       0);
        chk({tag, "_in_line"},  int'(in_line),      0);
        chk({tag, "_wr_en"},    int'(lb_wr_en),     0);
        chk({tag, "_wr_sel"},   int'(lb_wr_sel),    0);
        chk({tag, "_wvalid"},   int'(window_valid), 0);
        chk({tag, "_out_col"},  int'(out_col),      0);
        chk({tag, "_out_line"}, int'(out_line),     0);
        chk({tag, "_border"},   int'(border),       0);
        chk({tag, "_flush"},    int'(flush_active), 0);
        chk({tag, "_done"},     int'(frame_done),   0);
`ifdef SCHED_OVERRUN_FLAG_EN
        chk({tag, "_overrun"},  int'(overrun),      0);
`endif
    endtask

    initial begin
        //              v  we sel col ln wv oc ol bd fl dn
        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 1, 1, 2, 1, 1, 0, 0, 1, 0, 0);
        tbl[7]  = mk(1, 1, 1, 3, 1, 1, 1, 0, 1, 0, 0);
        tbl[8]  = mk(1, 1, 2, 0, 2, 1, 2, 0, 1, 0, 0);
        tbl[9]  = mk(1, 1, 2, 1, 2, 1, 3, 0, 1, 0, 0);
        tbl[10] = mk(1, 1, 2, 2, 2, 1, 0, 1, 1, 0, 0);
        tbl[11] = mk(1, 1, 2, 3, 2, 1, 1, 1, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 1, 2, 1, 0, 1, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 1, 3, 1, 1, 1, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 1, 0, 2, 1, 1, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 1, 1, 2, 1, 1, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 1, 2, 2, 1, 1, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 1, 3, 2, 1, 0, 1);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        resetn           = 1'b0;
        input_data_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Contiguous frame
        apply_rows(0, 19);

        // Alternating valid: model tracks the expected next input position
        begin
            int  acc = 0, mcol = 0, mline = 0, nwv = 0, ndone = 0;
            logic prev_we = 1'b0, prev_fl = 1'b0;
            for (int c = 0; c < 40; c++) begin
                input_data_valid = (acc < 12) && (c % 2 == 0);
                @(negedge clk);
                if (acc < 12) begin
                    chk("tog_wr_en", int'(lb_wr_en), int'(input_data_valid));
                    chk("tog_in_col", int'(in_col), mcol);
                    chk("tog_in_line", int'(in_line), mline);
                end
                if (window_valid) begin
                    chk("tog_wv_cause", int'(prev_we | prev_fl), 1);
                    chk("tog_out_col", int'(out_col), nwv % W);
                    chk("tog_out_line", int'(out_line), nwv / W);
                    nwv++;
                end
                if (frame_done) ndone++;
                if (lb_wr_en) begin
                    acc++;
                    if (mcol == W - 1) begin
                        mcol  = 0;
                        mline = (mline == H - 1) ? 0 : mline + 1;
                    end else begin
                        mcol++;
                    end
                end
                prev_we = lb_wr_en;
                prev_fl = flush_active;
                @(posedge clk);
                #1;
            end
            chk("tog_wv_count", nwv, 12);
            chk("tog_done_count", ndone, 1);
            chk("tog_end_in_col", int'(in_col), 0);
            chk("tog_end_in_line", int'(in_line), 0);
        end

        // Reset asserted one cycle after the 7th accepted pixel
        apply_rows(0, 7);
        input_data_valid = 1'b0;
        resetn = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_no_done", int'(frame_done), 0);
            chk("midrst_no_wv", int'(window_valid), 0);
            @(posedge clk);
            #1;
        end
        apply_rows(0, 19);

        // Valid held high through FLUSH and DONE: those pixels are dropped
        begin
            int nwv = 0, ndone = 0;
            for (int c = 0; c < 20; c++) begin
                input_data_valid = (c < 18);
                @(negedge clk);
                if (flush_active || frame_done) chk("ovr_wr_en_blocked", int'(lb_wr_en), 0);
                if (window_valid) nwv++;
                if (frame_done) ndone++;
                @(posedge clk);
                #1;
            end
            chk("ovr_wv_count", nwv, 12);
            chk("ovr_done_count", ndone, 1);
            chk("ovr_idle_in_col", int'(in_col), 0);
`ifdef SCHED_OVERRUN_FLAG_EN
            chk("ovr_flag", int'(overrun), 1);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
